// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg
//   Symbols shared by the Pong match controller and its helpers:
//   game state encodings (also shown on the debug LEDs), winner codes,
//   default timing constants and the speed-level saturation helper.
package game_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    WIN   = 3'd5
  } game_state_t;

  localparam logic [1:0] WINNER_NONE = 2'd0;
  localparam logic [1:0] WINNER_P1   = 2'd1;
  localparam logic [1:0] WINNER_P2   = 2'd2;

  localparam int DEFAULT_WIN_SCORE       = 7;
  localparam int DEFAULT_SERVE_TICKS     = 60;
  localparam int DEFAULT_POINT_TICKS     = 30;
  localparam int DEFAULT_WIN_TICKS       = 180;
  localparam int DEFAULT_SPEEDUP_HITS    = 4;
  localparam int DEFAULT_MAX_SPEED       = 3;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

  // Next speed level, holding once max_level is reached.
  function automatic logic [1:0] speed_up(input logic [1:0] level,
                                          input logic [1:0] max_level);
    return (level == max_level) ? level : level + 2'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_key_debouncer.sv
// key_debouncer
//   Cleans up one raw active-low FPGA key: synchroniser chain, stability
//   counter, and a one-cycle press pulse on the debounced falling edge.
//   A key held down yields exactly one press; releasing yields none.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (key treated as released)
//   key_n  in  raw active-low key, asynchronous to clk
//   press  out one-cycle pulse when the debounced key goes pressed
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   stable_reg;
  logic                   press_reg;
  logic                   key_sync;

  assign key_sync = sync_reg[SYNC_STAGES-1];
  assign press    = press_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg   <= '1;
      cnt_reg    <= '0;
      stable_reg <= 1'b1;
      press_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], key_n};
      press_reg <= 1'b0;
      // Any return to the accepted level restarts the stability window,
      // so bounces shorter than DEBOUNCE_CYCLES never get through.
      if (key_sync == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= key_sync;
        cnt_reg    <= '0;
        press_reg  <= ~key_sync;
      end else begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer
//   Match-level controller for the Pong datapath: game FSM, scores, serve
//   direction, ball speed level, run gating and ball-reset pulses. Timing
//   is counted in ball-clock ticks.
// Ports:
//   CLOCK_25     in  25 MHz system clock
//   reset        in  asynchronous active-high reset
//   tick         in  one-cycle pulse per ball-clock period
//   start_key_n  in  raw active-low start/pause key
//   miss_1/2     in  ball passed player 1/2 (the other player scores)
//   hit          in  any paddle hit
//   run          out ball and paddles may move
//   ball_reset   out one-cycle pulse, recentre the ball
//   serve_left   out next serve travels toward player 1
//   score_1/2    out player scores
//   winner       out 0 none, 1 player 1, 2 player 2
//   speed_level  out ball speed index 0..MAX_SPEED
//   state        out current FSM state for debug LEDs
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int WIN_SCORE       = DEFAULT_WIN_SCORE,
  parameter int SERVE_TICKS     = DEFAULT_SERVE_TICKS,
  parameter int POINT_TICKS     = DEFAULT_POINT_TICKS,
  parameter int WIN_TICKS       = DEFAULT_WIN_TICKS,
  parameter int SPEEDUP_HITS    = DEFAULT_SPEEDUP_HITS,
  parameter int MAX_SPEED       = DEFAULT_MAX_SPEED,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_key_n,
  input  logic       miss_1,
  input  logic       miss_2,
  input  logic       hit,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [1:0] winner,
  output logic [1:0] speed_level,
  output logic [2:0] state
);

  localparam int HW = $clog2(SPEEDUP_HITS + 1);
  // Timer expiry fires on the tick that would make the count hit the target.
  localparam logic [7:0]    SERVE_LAST = 8'(SERVE_TICKS - 1);
  localparam logic [7:0]    POINT_LAST = 8'(POINT_TICKS - 1);
  localparam logic [7:0]    WIN_LAST   = 8'(WIN_TICKS - 1);
  localparam logic [2:0]    WIN_SC     = 3'(WIN_SCORE);
  localparam logic [1:0]    MAX_LVL    = 2'(MAX_SPEED);
  localparam logic [HW-1:0] HIT_LAST   = HW'(SPEEDUP_HITS - 1);
  localparam logic [HW-1:0] HIT_ONE    = HW'(1);

  game_state_t   state_reg, state_next;
  logic [7:0]    timer_reg, timer_next;
  logic [2:0]    score_1_reg, score_1_next;
  logic [2:0]    score_2_reg, score_2_next;
  logic [1:0]    winner_reg, winner_next;
  logic [1:0]    speed_reg, speed_next;
  logic [HW-1:0] hit_cnt_reg, hit_cnt_next;
  logic          serve_left_reg, serve_left_next;
  logic          ball_reset_reg, ball_reset_next;
  logic          press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_key (
    .clk   (CLOCK_25),
    .reset (reset),
    .key_n (start_key_n),
    .press (press)
  );

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      score_1_reg    <= '0;
      score_2_reg    <= '0;
      winner_reg     <= WINNER_NONE;
      speed_reg      <= '0;
      hit_cnt_reg    <= '0;
      serve_left_reg <= 1'b0;
      ball_reset_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      score_1_reg    <= score_1_next;
      score_2_reg    <= score_2_next;
      winner_reg     <= winner_next;
      speed_reg      <= speed_next;
      hit_cnt_reg    <= hit_cnt_next;
      serve_left_reg <= serve_left_next;
      ball_reset_reg <= ball_reset_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    timer_next      = timer_reg;
    score_1_next    = score_1_reg;
    score_2_next    = score_2_reg;
    winner_next     = winner_reg;
    speed_next      = speed_reg;
    hit_cnt_next    = hit_cnt_reg;
    serve_left_next = serve_left_reg;
    ball_reset_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (press) begin
          state_next      = SERVE;
          timer_next      = '0;
          ball_reset_next = 1'b1;
          score_1_next    = '0;
          score_2_next    = '0;
          winner_next     = WINNER_NONE;
        end
      end
      SERVE: begin
        if (tick) begin
          if (timer_reg == SERVE_LAST) begin
            state_next = PLAY;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      PLAY: begin
        // miss_1 outranks miss_2, and any miss outranks hit and press.
        if (miss_1 || miss_2) begin
          timer_next   = '0;
          speed_next   = '0;
          hit_cnt_next = '0;
          state_next   = POINT;
          if (miss_1) begin
            score_2_next    = score_2_reg + 3'd1;
            serve_left_next = 1'b1;
            if (score_2_reg + 3'd1 == WIN_SC) begin
              state_next  = WIN;
              winner_next = WINNER_P2;
            end
          end else begin
            score_1_next    = score_1_reg + 3'd1;
            serve_left_next = 1'b0;
            if (score_1_reg + 3'd1 == WIN_SC) begin
              state_next  = WIN;
              winner_next = WINNER_P1;
            end
          end
        end else begin
          if (hit) begin
            if (hit_cnt_reg == HIT_LAST) begin
              hit_cnt_next = '0;
              speed_next   = speed_up(speed_reg, MAX_LVL);
            end else begin
              hit_cnt_next = hit_cnt_reg + HIT_ONE;
            end
          end
          if (press) begin
            state_next = PAUSE;
            timer_next = '0;
          end
        end
      end
      PAUSE: begin
        if (press) begin
          state_next = PLAY;
          timer_next = '0;
        end
      end
      POINT: begin
        if (tick) begin
          if (timer_reg == POINT_LAST) begin
            state_next      = SERVE;
            timer_next      = '0;
            ball_reset_next = 1'b1;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      WIN: begin
        // Scores and winner stay visible until the next press in IDLE.
        if (tick) begin
          if (timer_reg == WIN_LAST) begin
            state_next = IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign run         = (state_reg == PLAY);
  assign ball_reset  = ball_reset_reg;
  assign serve_left  = serve_left_reg;
  assign score_1     = score_1_reg;
  assign score_2     = score_2_reg;
  assign winner      = winner_reg;
  assign speed_level = speed_reg;
  assign state       = state_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
//   Self-checking bench for game_sequencer: a vector table of multi-cycle
//   stimulus steps with hand-derived expected outputs, hand-written key,
//   win, pause, bounce and async-reset sequences, and a randomized phase.
//   Every cycle is also compared against a behavioural match model.
module tb_game_sequencer;

  localparam int DC       = 40;   // shortened debounce window
  localparam int SERVE_T  = 60;
  localparam int POINT_T  = 30;
  localparam int WIN_T    = 180;
  localparam int WIN_SC   = 7;
  localparam int HITS_PER = 4;
  localparam int MAX_SPD  = 3;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_POINT = 4, S_WIN = 5;

  logic       clk = 1'b0;
  logic       reset, tick, start_key_n, miss_1, miss_2, hit;
  logic       run, ball_reset, serve_left;
  logic [2:0] score_1, score_2, state;
  logic [1:0] winner, speed_level;

  always #20 clk = ~clk;

  game_sequencer #(
    .WIN_SCORE(WIN_SC), .SERVE_TICKS(SERVE_T), .POINT_TICKS(POINT_T),
    .WIN_TICKS(WIN_T), .SPEEDUP_HITS(HITS_PER), .MAX_SPEED(MAX_SPD),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .CLOCK_25(clk), .reset(reset), .tick(tick), .start_key_n(start_key_n),
    .miss_1(miss_1), .miss_2(miss_2), .hit(hit),
    .run(run), .ball_reset(ball_reset), .serve_left(serve_left),
    .score_1(score_1), .score_2(score_2), .winner(winner),
    .speed_level(speed_level), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural match model: remaining ticks instead of a timer, total
  // rally hits instead of a wrap-around counter.
  int m_state, m_s1, m_s2, m_win, m_rally, m_left;
  bit m_sl, m_br;
  bit press_seen;

  function automatic void model_reset();
    m_state = S_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
    m_rally = 0; m_left = 0; m_sl = 0; m_br = 0;
  endfunction

  function automatic int m_speed();
    return (m_rally / HITS_PER > MAX_SPD) ? MAX_SPD : m_rally / HITS_PER;
  endfunction

  function automatic void model_step(input bit t, input bit m1, input bit m2,
                                     input bit h, input bit p);
    m_br = 0;
    case (m_state)
      S_IDLE: if (p) begin
        m_state = S_SERVE; m_left = SERVE_T; m_br = 1;
        m_s1 = 0; m_s2 = 0; m_win = 0;
      end
      S_SERVE: if (t) begin
        m_left--;
        if (m_left == 0) m_state = S_PLAY;
      end
      S_PLAY: begin
        if (m1 || m2) begin
          m_rally = 0;
          if (m1) begin m_s2++; m_sl = 1; end
          else    begin m_s1++; m_sl = 0; end
          if (m_s2 == WIN_SC || m_s1 == WIN_SC) begin
            m_state = S_WIN; m_left = WIN_T; m_win = m1 ? 2 : 1;
          end else begin
            m_state = S_POINT; m_left = POINT_T;
          end
        end else begin
          if (h) m_rally++;
          if (p) m_state = S_PAUSE;
        end
      end
      S_PAUSE: if (p) m_state = S_PLAY;
      S_POINT: if (t) begin
        m_left--;
        if (m_left == 0) begin m_state = S_SERVE; m_left = SERVE_T; m_br = 1; end
      end
      S_WIN: if (t) begin
        m_left--;
        if (m_left == 0) m_state = S_IDLE;
      end
      default: m_state = S_IDLE;
    endcase
  endfunction

  task automatic check(input string nm);
    logic [15:0] act, exp;
    act = {state, run, ball_reset, serve_left, score_1, score_2, winner, speed_level};
    exp = {3'(m_state), (m_state == S_PLAY), m_br, m_sl, 3'(m_s1), 3'(m_s2),
           2'(m_win), 2'(m_speed())};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (st|run|br|sl|s1|s2|win|spd)", nm, act, exp);
    end
  endtask

  task automatic check_const(input string nm, input int st, input int s1, input int s2,
                             input int w, input int spd, input bit sl);
    logic [14:0] act, exp;
    act = {state, score_1, score_2, winner, speed_level, serve_left, run};
    exp = {3'(st), 3'(s1), 3'(s2), 2'(w), 2'(spd), sl, (st == S_PLAY)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (st|s1|s2|win|spd|sl|run)", nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns after posedge.
  task automatic step(input bit t, input bit m1, input bit m2, input bit h,
                      input bit allow_p, input string nm);
    @(negedge clk);
    tick = t; miss_1 = m1; miss_2 = m2; hit = h;
    @(posedge clk);
    #1;
    if (allow_p && !press_seen && state !== 3'(m_state)) begin
      press_seen = 1;
      model_step(t, m1, m2, h, 1'b1);
    end else begin
      model_step(t, m1, m2, h, 1'b0);
    end
    check(nm);
  endtask

  task automatic ticks(input int n, input string nm);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, nm);
  endtask

  // Press and hold the key, then release; the debounced press must land
  // inside a bounded window and only once.
  task automatic press_key(input bit expect_change, input string nm);
    press_seen = 0;
    start_key_n = 1'b0;
    for (int i = 0; i < DC + 16; i++) step(0, 0, 0, 0, 1, nm);
    n_cmp++;
    if (press_seen != expect_change) begin
      n_bad++;
      $display("FAIL %s press_detect: got %0d want %0d", nm, press_seen, expect_change);
    end
    for (int i = 0; i < 2 * DC; i++) step(0, 0, 0, 0, 0, nm);
    start_key_n = 1'b1;
    for (int i = 0; i < DC + 8; i++) step(0, 0, 0, 0, 0, nm);
    $display("key %s: state=%0d s1=%0d s2=%0d winner=%0d", nm, state, score_1, score_2, winner);
  endtask

  typedef struct {
    int rep; bit t; bit m1; bit m2; bit h;
    int st; int s1; int s2; int spd; bit sl;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int prev;
    reset = 1'b1; tick = 0; miss_1 = 0; miss_2 = 0; hit = 0; start_key_n = 1'b1;
    press_seen = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state");
    @(negedge clk);
    reset = 1'b0;

    // Test 1: start key -> SERVE with one ball_reset pulse.
    press_key(1, "t1_start");
    check_const("t1_serve", S_SERVE, 0, 0, 0, 0, 0);

    vecs[0]  = '{59, 1, 0, 0, 0, S_SERVE, 0, 0, 0, 0};
    vecs[1]  = '{1,  1, 0, 0, 0, S_PLAY,  0, 0, 0, 0};
    vecs[2]  = '{9,  0, 0, 0, 1, S_PLAY,  0, 0, 2, 0};
    vecs[3]  = '{8,  0, 0, 0, 1, S_PLAY,  0, 0, 3, 0};
    vecs[4]  = '{1,  0, 0, 1, 0, S_POINT, 1, 0, 0, 0};
    vecs[5]  = '{29, 1, 0, 0, 0, S_POINT, 1, 0, 0, 0};
    vecs[6]  = '{1,  1, 0, 0, 0, S_SERVE, 1, 0, 0, 0};
    vecs[7]  = '{60, 1, 0, 0, 0, S_PLAY,  1, 0, 0, 0};
    vecs[8]  = '{1,  0, 1, 1, 0, S_POINT, 1, 1, 0, 1};
    vecs[9]  = '{3,  0, 0, 0, 1, S_POINT, 1, 1, 0, 1};
    vecs[10] = '{30, 1, 0, 0, 0, S_SERVE, 1, 1, 0, 1};
    vecs[11] = '{60, 1, 0, 0, 0, S_PLAY,  1, 1, 0, 1};
    vecs[12] = '{3,  1, 0, 0, 1, S_PLAY,  1, 1, 0, 1};
    vecs[13] = '{1,  0, 0, 0, 1, S_PLAY,  1, 1, 1, 1};

    for (int k = 0; k < 14; k++) begin
      for (int r = 0; r < vecs[k].rep; r++)
        step(vecs[k].t, vecs[k].m1, vecs[k].m2, vecs[k].h, 0, $sformatf("vec%0d", k));
      check_const($sformatf("vec%0d_end", k), vecs[k].st, vecs[k].s1, vecs[k].s2, 0,
                  vecs[k].spd, vecs[k].sl);
      $display("vec%0d: rep=%0d state=%0d s1=%0d s2=%0d spd=%0d", k, vecs[k].rep,
               state, score_1, score_2, speed_level);
    end

    // Test 3: drive player 2 to 6, then the winning miss.
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 0, 0, 0, "t3_miss");
      ticks(POINT_T, "t3_point");
      ticks(SERVE_T, "t3_serve");
    end
    check_const("t3_six", S_PLAY, 1, 6, 0, 0, 1);
    step(0, 1, 0, 0, 0, "t3_win_miss");
    check_const("t3_win", S_WIN, 1, 7, 2, 0, 1);
    ticks(100, "t3_win_a");
    press_key(0, "t3_press_in_win");
    ticks(79, "t3_win_b");
    check_const("t3_win_hold", S_WIN, 1, 7, 2, 0, 1);
    ticks(1, "t3_win_end");
    check_const("t3_idle", S_IDLE, 1, 7, 2, 0, 1);
    press_key(1, "t3_restart");
    check_const("t3_cleared", S_SERVE, 0, 0, 0, 0, 1);

    // Test 6: pause, ignored events, resume, bounce, async reset.
    ticks(SERVE_T, "t6_serve");
    press_key(1, "t6_pause");
    check_const("t6_paused", S_PAUSE, 0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) step(1, (i == 25), 0, (i % 7 == 0), 0, "t6_frozen");
    check_const("t6_frozen_end", S_PAUSE, 0, 0, 0, 0, 1);
    press_key(1, "t6_resume");
    check_const("t6_play", S_PLAY, 0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      start_key_n = ~start_key_n;
      for (int i = 0; i < DC / 2; i++) step(0, 0, 0, 0, 0, "t6_bounce");
    end
    for (int i = 0; i < DC + 8; i++) step(0, 0, 0, 0, 0, "t6_settle");
    check_const("t6_bounce_end", S_PLAY, 0, 0, 0, 0, 1);
    press_key(1, "t6_pause2");
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("t6_async_reset");
    $display("async reset: state=%0d run=%0d sl=%0d", state, run, serve_left);
    @(negedge clk);
    reset = 1'b0;

    // Randomized matches against the model.
    press_key(1, "rnd_start");
    prev = m_state;
    for (int i = 0; i < 9000; i++) begin
      if (m_state == S_IDLE) begin
        press_key(1, "rnd_restart");
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0, 0, "rnd");
      end
      if (m_state == S_WIN && prev != S_WIN)
        $display("rnd match over: s1=%0d s2=%0d winner=%0d", score_1, score_2, winner);
      prev = m_state;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Match-level controller for the Pong datapath.
- Owns the game FSM (idle, serve, play, pause, point, win), both 3-bit scores, serve direction and ball speed level.
- Gates object motion through a run enable, issues ball-reset pulses, and turns raw miss/hit events from the ball logic into score updates.
- Sits between the key inputs and the image generator; all timing is counted in ball-clock ticks.

Parameters:
- WIN_SCORE, 7, score that ends the match (1..7).
- SERVE_TICKS, 60, ticks the ball is held at centre before a serve.
- POINT_TICKS, 30, freeze ticks after a point.
- WIN_TICKS, 180, ticks the winner is displayed.
- SPEEDUP_HITS, 4, paddle hits per speed increment.
- MAX_SPEED, 3, speed_level saturation value.
- DEBOUNCE_CYCLES, 250000, CLOCK_25 cycles the key must be stable (10 ms).

Ports:
- CLOCK_25 in 1: system clock, 25 MHz.
- reset in 1: asynchronous, active-high reset.
- tick in 1: one-cycle pulse per ball-clock period, synchronous to CLOCK_25.
- start_key_n in 1: raw FPGA key, active-low, asynchronous.
- miss_1 in 1: one-cycle pulse; ball passed player 1, so player 2 scores.
- miss_2 in 1: one-cycle pulse; ball passed player 2, so player 1 scores.
- hit in 1: one-cycle pulse on any paddle hit.
- run out 1: 1 = ball and paddles may move.
- ball_reset out 1: one-cycle pulse; datapath recentres the ball.
- serve_left out 1: 1 = next serve travels toward player 1.
- score_1 out 3: player 1 score.
- score_2 out 3: player 2 score.
- winner out 2: 0 none, 1 player 1, 2 player 2.
- speed_level out 2: ball speed index, 0..MAX_SPEED.
- state out 3: current FSM state, for debug LEDs.

Behaviour:
- Reset values (asynchronous): state IDLE, run 0, ball_reset 0, serve_left 0, scores 0, winner 0, speed_level 0, timer 0, hit counter 0.
- Key path:
  - 2-flop synchroniser, then debounce counter.
  - Emits press, a one-cycle pulse on the debounced high-to-low transition of start_key_n.
  - A held key produces exactly one press.
- FSM, all transitions registered (one-cycle latency from event to new state and outputs):
  - IDLE:
    - run 0.
    - press -> SERVE, pulse ball_reset, clear both scores and winner.
  - SERVE:
    - run 0; timer counts tick.
    - At SERVE_TICKS ticks -> PLAY.
    - press is ignored.
  - PLAY:
    - run 1.
    - miss_1: score_2 += 1, serve_left <= 1, go to POINT (or WIN if the new score_2 == WIN_SCORE, with winner <= 2).
    - miss_2: symmetric, with serve_left <= 0 and winner <= 1.
    - press -> PAUSE.
  - PAUSE:
    - run 0; timer frozen; misses and hits ignored.
    - press -> PLAY.
  - POINT:
    - run 0.
    - After POINT_TICKS ticks -> SERVE, pulsing ball_reset on the transition cycle.
  - WIN:
    - run 0.
    - After WIN_TICKS ticks -> IDLE. Scores and winner are held until the next press in IDLE.
    - press is ignored.
- Timer:
  - 8-bit, cleared on every state entry.
  - Increments only on tick.
  - Expiry is evaluated on the tick that makes the count equal to the target.
- Simultaneous events:
  - miss_1 and miss_2 in the same cycle: miss_1 takes priority and miss_2 is dropped.
  - miss and press in the same cycle: the miss takes priority, press is dropped.
  - miss, hit or tick outside PLAY (timer ticks aside): no effect.
- Speed:
  - hit in PLAY increments the rally counter.
  - When the count reaches SPEEDUP_HITS, the counter clears and speed_level increments, saturating at MAX_SPEED.
  - Rally counter and speed_level clear on entry to POINT or WIN.
- Scores are 3-bit and never wrap, because WIN_SCORE ≤ 7 ends the match first.
- Reset asserted mid-match: immediate return to the reset values; ball_reset is not pulsed by reset itself.

Decomposition:
- Shared include global_symbols.vh:
  - state encodings: IDLE 0, SERVE 1, PLAY 2, PAUSE 3, POINT 4, WIN 5;
  - winner codes;
  - default tick constants.
- Sub-module key_debouncer (synchroniser, stability counter, falling-edge press pulse), reusable for other FPGA keys.

Test Plan:
1. Reset, then start_key_n low for 300000 cycles -> exactly one ball_reset pulse; state SERVE; run 0; after 60 ticks state PLAY and run 1.
2. In PLAY, pulse miss_2 -> next cycle score_1 = 1, serve_left 0, state POINT, run 0; after 30 ticks ball_reset pulse and state SERVE.
3. score_2 = 6, pulse miss_1 -> score_2 = 7, winner 2, state WIN; after 180 ticks state IDLE; next press clears scores to 0.
4. miss_1 and miss_2 in the same cycle -> only score_2 increments; score_1 unchanged.
5. 9 hit pulses in PLAY with SPEEDUP_HITS 4 -> speed_level 2; 8 further hits -> saturates at 3; miss -> speed_level 0.
6. Press in PLAY -> PAUSE; 50 ticks plus a miss_1 pulse -> no score change; press -> PLAY. Then key bounce of 10 toggles of 1000 cycles each -> no press. Then reset asserted in PAUSE -> all outputs return to reset values asynchronously.
